// File: rtl/bus_decode_pkg.sv
// Shared types and default memory-map constants for the bus address decoder.
package bus_decode_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  typedef logic [3:0] ws_t;

  localparam int unsigned DefAddrW = 13;
  localparam int unsigned DefNreg  = 2;

  // Region 0 is RAM, region 1 is ROM.
  localparam logic [12:0] RamBase = 13'h0000;
  localparam logic [12:0] RamLast = 13'h17FF;
  localparam ws_t         RamWs   = 4'd1;
  localparam logic [12:0] RomBase = 13'h1800;
  localparam logic [12:0] RomLast = 13'h1FFF;
  localparam ws_t         RomWs   = 4'd0;

endpackage

// File: rtl/bus_decode_if.sv
// Request/response signal bundle between a bus requester and bus_decode.
interface bus_decode_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned NREG   = 2
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [NREG-1:0]   sel;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, input sel, ack, err, busy);
  modport slave  (input req, we, addr, output sel, ack, err, busy);
endinterface

// File: rtl/bus_region_match.sv
// Combinational address range match with lowest-index priority over overlapping regions.
module bus_region_match #(
  parameter int unsigned           ADDR_W   = 13,
  parameter int unsigned           NREG     = 2,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [NREG*ADDR_W-1:0] REG_LAST = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NREG-1:0]   hit_o,
  output logic              any_o
);

  // Walk from the highest index down so the lowest matching region overwrites the rest.
  always_comb begin
    hit_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (addr_i >= REG_BASE[i*ADDR_W +: ADDR_W] && addr_i <= REG_LAST[i*ADDR_W +: ADDR_W]) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
      end
    end
  end

  assign any_o = |hit_o;

endmodule

// File: rtl/bus_decode.sv
// Bus address decoder: region select, per-region wait states and ack/err pulses.
// Define BUS_DECODE_WP_EN to make writes to region 0 complete as protection errors.
module bus_decode
  import bus_decode_pkg::*;
#(
  parameter int unsigned            ADDR_W   = DefAddrW,
  parameter int unsigned            NREG     = DefNreg,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = {RomBase, RamBase},
  parameter logic [NREG*ADDR_W-1:0] REG_LAST = {RomLast, RamLast},
  parameter logic [NREG*4-1:0]      REG_WS   = {RomWs, RamWs}
) (
  input logic        clk,
  input logic        rst,
  bus_decode_if.slave bus
);

  state_e          state_q, state_d;
  ws_t             cnt_q, cnt_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic            err_q, err_d;

  logic [NREG-1:0] hit;
  logic            any_hit;
  ws_t             hit_ws;
  logic            wp_viol;

  bus_region_match #(
    .ADDR_W   (ADDR_W),
    .NREG     (NREG),
    .REG_BASE (REG_BASE),
    .REG_LAST (REG_LAST)
  ) u_match (
    .addr_i (bus.addr),
    .hit_o  (hit),
    .any_o  (any_hit)
  );

  always_comb begin
    hit_ws = '0;
    for (int i = 0; i < NREG; i++) begin
      if (hit[i]) hit_ws = hit_ws | REG_WS[i*4 +: 4];
    end
  end

`ifdef BUS_DECODE_WP_EN
  assign wp_viol = bus.we & hit[0];
`else
  assign wp_viol = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // Decode happens only at acceptance; later addr/we changes cannot disturb the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          if (!any_hit || wp_viol) begin
            state_d = StDone;
            sel_d   = '0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = StWait;
            sel_d   = hit;
            err_d   = 1'b0;
            cnt_d   = hit_ws;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - ws_t'(1);
      end
      StDone: begin
        state_d = StIdle;
        sel_d   = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.sel  = sel_q;
    bus.ack  = (state_q == StDone);
    bus.err  = err_q & (state_q == StDone);
    bus.busy = (state_q != StIdle);
  end

endmodule

// File: tb/tb_bus_decode.sv
// Directed self-checking bench for bus_decode (default map plus two 3-region maps).
module tb_bus_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bus_decode_if #(.ADDR_W(13), .NREG(2)) b0 ();
  bus_decode_if #(.ADDR_W(13), .NREG(3)) b1 ();
  bus_decode_if #(.ADDR_W(13), .NREG(3)) b2 ();

  bus_decode u0 (.clk(clk), .rst(rst), .bus(b0));

  bus_decode #(
    .ADDR_W   (13),
    .NREG     (3),
    .REG_BASE ({13'h0000, 13'h1800, 13'h0000}),
    .REG_LAST ({13'h00FF, 13'h1FFF, 13'h17FF}),
    .REG_WS   ({4'd0, 4'd0, 4'd1})
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  bus_decode #(
    .ADDR_W   (13),
    .NREG     (3),
    .REG_BASE ({13'h0000, 13'h1800, 13'h0200}),
    .REG_LAST ({13'h00FF, 13'h1FFF, 13'h17FF}),
    .REG_WS   ({4'd0, 4'd0, 4'd1})
  ) u2 (.clk(clk), .rst(rst), .bus(b2));

  // One access on the default DUT; addr/we are scrambled right after acceptance.
  task automatic acc0(input logic [12:0] a, input logic w, output int lat,
                      output logic [1:0] s, output logic e, output logic bsy1);
    @(negedge clk);
    b0.req = 1'b1; b0.we = w; b0.addr = a;
    @(posedge clk); #1;
    b0.req = 1'b0; b0.we = ~w; b0.addr = ~a;
    lat = 0; s = '0; e = 1'b0; bsy1 = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) bsy1 = b0.busy;
      if (b0.ack) begin lat = k; s = b0.sel; e = b0.err; end
    end
  endtask

  task automatic acc3(input int which, input logic [12:0] a, output int lat,
                      output logic [2:0] s, output logic e);
    @(negedge clk);
    if (which == 1) begin b1.req = 1'b1; b1.addr = a; end
    else            begin b2.req = 1'b1; b2.addr = a; end
    @(posedge clk); #1;
    b1.req = 1'b0; b2.req = 1'b0;
    lat = 0; s = '0; e = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (which == 1 && b1.ack) begin lat = k; s = b1.sel; e = b1.err; end
      if (which == 2 && b2.ack) begin lat = k; s = b2.sel; e = b2.err; end
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({b0.sel, b0.ack, b0.err, b0.busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b want 00000", {b0.sel, b0.ack, b0.err, b0.busy});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b0.busy !== 1'b0 || b0.ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy %b ack %b want 0 0", b0.busy, b0.ack);
    end
  endtask

  task automatic test_ram_read;
    int lat; logic [1:0] s; logic e, bsy;
    acc0(13'h0100, 1'b0, lat, s, e, bsy);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ram_lat: got %0d want 3", lat); end
    n_checks++; if (s !== 2'b01) begin n_fail++; $display("FAIL ram_sel: got %b want 01", s); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL ram_err: got %b want 0", e); end
    n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL ram_busy: got %b want 1", bsy); end
    @(negedge clk);
    n_checks++;
    if (b0.sel !== 2'b00 || b0.busy !== 1'b0 || b0.ack !== 1'b0) begin
      n_fail++; $display("FAIL ram_idle: sel %b busy %b ack %b want 00 0 0", b0.sel, b0.busy, b0.ack);
    end
  endtask

  task automatic test_rom_read;
    int lat; logic [1:0] s; logic e, bsy;
    acc0(13'h1800, 1'b0, lat, s, e, bsy);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rom_lat: got %0d want 2", lat); end
    n_checks++; if (s !== 2'b10) begin n_fail++; $display("FAIL rom_sel: got %b want 10", s); end
    acc0(13'h17FF, 1'b0, lat, s, e, bsy);
    n_checks++; if (lat !== 3 || s !== 2'b01) begin
      n_fail++; $display("FAIL ram_top: lat %0d sel %b want 3 01", lat, s);
    end
    acc0(13'h1FFF, 1'b0, lat, s, e, bsy);
    n_checks++; if (lat !== 2 || s !== 2'b10 || e !== 1'b0) begin
      n_fail++; $display("FAIL rom_top: lat %0d sel %b err %b want 2 10 0", lat, s, e);
    end
  endtask

  task automatic test_write;
    int lat; logic [1:0] s; logic e, bsy;
`ifdef BUS_DECODE_WP_EN
    acc0(13'h0010, 1'b1, lat, s, e, bsy);
    n_checks++; if (lat !== 1 || s !== 2'b00 || e !== 1'b1) begin
      n_fail++; $display("FAIL wp_viol: lat %0d sel %b err %b want 1 00 1", lat, s, e);
    end
    acc0(13'h1900, 1'b1, lat, s, e, bsy);
    n_checks++; if (lat !== 2 || s !== 2'b10 || e !== 1'b0) begin
      n_fail++; $display("FAIL wp_rom: lat %0d sel %b err %b want 2 10 0", lat, s, e);
    end
`else
    acc0(13'h0010, 1'b1, lat, s, e, bsy);
    n_checks++; if (lat !== 3 || s !== 2'b01 || e !== 1'b0) begin
      n_fail++; $display("FAIL wr_ram: lat %0d sel %b err %b want 3 01 0", lat, s, e);
    end
`endif
  endtask

  task automatic test_hole;
    int lat; logic [2:0] s; logic e;
    acc3(1, 13'h0080, lat, s, e);
    n_checks++; if (lat !== 3 || s !== 3'b001 || e !== 1'b0) begin
      n_fail++; $display("FAIL overlap: lat %0d sel %b err %b want 3 001 0", lat, s, e);
    end
    acc3(2, 13'h0180, lat, s, e);
    n_checks++; if (lat !== 1 || s !== 3'b000 || e !== 1'b1) begin
      n_fail++; $display("FAIL unmapped: lat %0d sel %b err %b want 1 000 1", lat, s, e);
    end
    acc3(2, 13'h0080, lat, s, e);
    n_checks++; if (lat !== 2 || s !== 3'b100 || e !== 1'b0) begin
      n_fail++; $display("FAIL region2: lat %0d sel %b err %b want 2 100 0", lat, s, e);
    end
  endtask

  task automatic test_busy_ignore;
    int acks = 0;
    @(negedge clk);
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 13'h0100;
    @(posedge clk); #1; b0.req = 1'b0;
    @(negedge clk); b0.req = 1'b1;
    if (b0.ack) acks++;
    @(negedge clk); b0.req = 1'b0;
    if (b0.ack) acks++;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (b0.ack) acks++; end
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL busy_ignore: got %0d acks want 1", acks); end
  endtask

  task automatic test_back_to_back;
    int acks = 0;
    logic last_ack;
    @(negedge clk);
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 13'h1800;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin @(negedge clk); if (b0.ack) acks++; end
    last_ack = b0.ack;
    b0.req = 1'b0;
    n_checks++; if (acks !== 2 || last_ack !== 1'b1) begin
      n_fail++; $display("FAIL back_to_back: acks %0d last %b want 2 1", acks, last_ack);
    end
    @(negedge clk); @(negedge clk);
    n_checks++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b want 0", b0.busy); end
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    @(negedge clk);
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 13'h0100;
    @(posedge clk); #1; b0.req = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    n_checks++; if ({b0.sel, b0.ack, b0.err, b0.busy} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid: got %b want 00000", {b0.sel, b0.ack, b0.err, b0.busy});
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (b0.ack || b0.busy) acks++; end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rst_no_ack: got %0d active cycles want 0", acks); end
  endtask

  initial begin
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0;
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0;
    b2.req = 1'b0; b2.we = 1'b0; b2.addr = '0;
    test_reset();
    test_ram_read();
    test_rom_read();
    test_write();
    test_hole();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_ram_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
